// File: rtl/fsm_packer_boxer.sv
// Packs sealed-product pulses into boxes of BOX_SIZE, ejects each full box,
// waits for its removal and counts completed boxes. Bad arrivals set a sticky error.
module fsm_packer_boxer #(
    parameter int unsigned BOX_SIZE     = 6,
    parameter int unsigned EJECT_CYCLES = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sealed_valid,
    input  logic             box_present,
    output logic             sealed_ready,
    output logic             packing,
    output logic             ejecting,
    output logic             drop_err,
    output logic [3:0]       item_count,
    output logic [CNT_W-1:0] box_count,
    output logic [1:0]       state_indicator
);

    localparam int unsigned ITEM_W = 4;
    localparam logic [ITEM_W-1:0] BOX_FULL   = ITEM_W'(BOX_SIZE);
    localparam logic [ITEM_W-1:0] EJECT_LOAD = ITEM_W'(EJECT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE        = 2'b00,
        S_FILL        = 2'b01,
        S_EJECT       = 2'b10,
        S_WAIT_REMOVE = 2'b11
    } state_t;

    state_t            state;
    logic [ITEM_W-1:0] eject_cnt;
    logic              accept;
    logic              drop;

    // Ready is the one combinational output: it gates the same-cycle accept.
    assign sealed_ready    = (state == S_FILL) && box_present && (item_count < BOX_FULL);
    assign accept          = sealed_valid && sealed_ready;
    assign drop            = sealed_valid && !sealed_ready;
    assign state_indicator = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            packing    <= 1'b0;
            ejecting   <= 1'b0;
            drop_err   <= 1'b0;
            item_count <= '0;
            box_count  <= '0;
            eject_cnt  <= '0;
        end else begin
            if (drop) begin
                drop_err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    item_count <= '0;
                    if (box_present) begin
                        state   <= S_FILL;
                        packing <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (!box_present) begin
                        // Partial box pulled away: its contents are lost.
                        state      <= S_IDLE;
                        packing    <= 1'b0;
                        item_count <= '0;
                        drop_err   <= 1'b1;
                    end else if (accept) begin
                        item_count <= item_count + ITEM_W'(1);
                        if ((item_count + ITEM_W'(1)) == BOX_FULL) begin
                            state     <= S_EJECT;
                            packing   <= 1'b0;
                            ejecting  <= 1'b1;
                            box_count <= box_count + CNT_W'(1);
                            eject_cnt <= EJECT_LOAD;
                        end
                    end
                end
                S_EJECT: begin
                    if (eject_cnt == '0) begin
                        state      <= S_WAIT_REMOVE;
                        ejecting   <= 1'b0;
                        item_count <= '0;
                    end else begin
                        eject_cnt <= eject_cnt - ITEM_W'(1);
                    end
                end
                S_WAIT_REMOVE: begin
                    // Only a removal lets a new box start; a lingering box is ignored.
                    if (!box_present) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
